regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 2-read/1-write CPU register file.
- Generalised in width and depth. Adds asynchronous reset clearing of all registers.
- Adds optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard. The issue stage sets a bit, writeback clears it, and pipeline flush clears all bits.
- Sits between decode/issue and writeback of the pipelined datapath. Register 0 is hardwired to zero.

Parameters:
- W, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREG), address width; derived, never overridden.
- BYPASS, 1, 1 = a read of the register being written this cycle returns wr_data; 0 = the read returns the old contents.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr1  in  AW  read port 1 address.
- rd_addr2  in  AW  read port 2 address.
- rd_data1  out  W  read port 1 data, combinational.
- rd_data2  out  W  read port 2 data, combinational.
- rd_busy1  out  1  busy flag of rd_addr1.
- rd_busy2  out  1  busy flag of rd_addr2.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback register.
- wr_data  in  W  writeback data.
- iss_en  in  1  issue strobe; marks iss_addr as pending.
- iss_addr  in  AW  destination register of the issued instruction.
- flush  in  1  clears all busy bits; data is untouched.
- busy_vec  out  NREG  registered busy bits; bit 0 always 0.
- any_busy  out  1  OR of busy_vec.
- waw_err  out  1  sticky flag: issue to an already-busy register.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - All registers = 0, busy_vec = 0, waw_err = 0.
  - While reset is held, rd_data* = 0, rd_busy* = 0, any_busy = 0.
  - Release is synchronous to the design; state changes only from the first posedge after release.
- Register 0:
  - Reads always 0 and is never busy.
  - Writes and issues to address 0 are ignored, including for waw_err.
- Write:
  - On posedge with wr_en=1 and wr_addr≠0, RF[wr_addr] ← wr_data. One-cycle latency to the non-bypassed read path.
- Read:
  - Purely combinational from rd_addr*.
  - rd_data = 0 for address 0; otherwise RF[addr].
  - Bypass override: BYPASS=1, wr_en=1, wr_addr==rd_addr≠0 → rd_data = wr_data and rd_busy = 0.
  - Both ports are independent; the same address on both ports is legal.
- Busy flags:
  - rd_busy = busy_vec[rd_addr], except during a bypass hit (above).
  - With BYPASS=0, rd_busy reflects the registered bit only.
- Scoreboard update per bit i≠0 each posedge, in priority order:
  1. flush=1 → busy[i] ← 0. A simultaneous issue is squashed and a simultaneous write still updates data.
  2. Else if iss_en=1 and iss_addr==i → busy[i] ← 1. Issue beats a same-cycle write clear, because the new producer is outstanding.
  3. Else if wr_en=1 and wr_addr==i → busy[i] ← 0.
  4. Else hold.
- waw_err:
  - Set on posedge when iss_en=1, flush=0, iss_addr≠0, busy[iss_addr]=1, and there is no same-cycle wr_en to iss_addr.
  - Cleared only by reset.
- Writeback to a non-busy register is legal: data is written and there is no error.
- any_busy is combinational from the busy_vec register.
- Reset asserted mid-operation discards all state immediately.

Decomposition:
- Shared package regfile_pkg holds:
  - Default W and NREG.
  - The zero-register index constant.
  - A function computing AW.
- One sub-module, rf_scoreboard, holds busy_vec, waw_err and the priority logic. Ports: clk, rst_n, iss_en/addr, wr_en/addr, flush, busy_vec, waw_err.
- Data storage and bypass muxes stay in regfile_sb.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5 and read r5 on both ports the next cycle → 0xDEADBEEF on both. Assert rst_n=0 asynchronously mid-cycle → rd_data1 = 0 immediately.
2. Write 0x12345678 to r0, then read r0 → 0. Issue r0 → busy_vec = 0 and waw_err = 0.
3. BYPASS=1: wr_en to r7 with 0xA5A5A5A5 while rd_addr1=7 → rd_data1 = 0xA5A5A5A5 in the same cycle. With BYPASS=0, the same stimulus → the old value in the same cycle and the new value in the next cycle.
4. Issue r3 → busy_vec[3]=1 and any_busy=1 next cycle. Writeback r3 → busy_vec[3]=0. Issue r3 plus a same-cycle writeback r3 → busy_vec[3]=1 and waw_err=0.
5. Issue r4, then issue r4 again with no writeback → waw_err=1 and it stays 1 after a later writeback clears busy.
6. Busy r2 and r9, then flush together with iss_en to r11 and wr_en to r2 with 0x55 → busy_vec = 0, RF[2] = 0x55, r11 not busy.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// the hardwired-zero register index and the address-width helper.
package regfile_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_NREG = 32;
  localparam int ZERO_REG = 0;

  // At least one address bit even for the smallest legal file.
  function automatic int calc_aw(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback
// clears it, flush clears everything; waw_err latches issue-to-busy events.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = calc_aw(DEF_NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec,
  output logic            waw_err
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [NREG-1:0] r_busy;
  logic            r_waw_err;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_waw_set;

  // Priority per bit: flush, then issue (new producer outstanding), then writeback.
  always_comb begin
    w_busy_nxt    = r_busy;
    w_busy_nxt[0] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (flush)
        w_busy_nxt[i] = 1'b0;
      else if (iss_en && (iss_addr == AW'(i)))
        w_busy_nxt[i] = 1'b1;
      else if (wr_en && (wr_addr == AW'(i)))
        w_busy_nxt[i] = 1'b0;
    end
    w_waw_set = iss_en && !flush && (iss_addr != ZERO_ADDR) && r_busy[iss_addr]
                && !(wr_en && (wr_addr == iss_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_waw_err <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_waw_set)
        r_waw_err <= 1'b1;
    end
  end

  assign busy_vec = r_busy;
  assign waw_err  = r_waw_err;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with r0 hardwired to zero, optional
// same-cycle write-to-read bypass and an attached busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int   W      = DEF_W,
  parameter int   NREG   = DEF_NREG,
  parameter bit   BYPASS = 1'b1,
  localparam int  AW     = calc_aw(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [W-1:0]    rd_data1,
  output logic [W-1:0]    rd_data2,
  output logic            rd_busy1,
  output logic            rd_busy2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec,
  output logic            any_busy,
  output logic            waw_err
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [W-1:0]    r_rf [NREG];
  logic [NREG-1:0] w_busy_vec;
  logic            w_hit1;
  logic            w_hit2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_rf[i] <= '0;
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      r_rf[wr_addr] <= wr_data;
    end
  end

  // Bypass is gated by rst_n so reads stay zero while reset is held.
  always_comb begin
    w_hit1 = BYPASS && rst_n && wr_en && (wr_addr == rd_addr1) && (rd_addr1 != ZERO_ADDR);
    w_hit2 = BYPASS && rst_n && wr_en && (wr_addr == rd_addr2) && (rd_addr2 != ZERO_ADDR);

    if (rd_addr1 == ZERO_ADDR) rd_data1 = '0;
    else if (w_hit1)           rd_data1 = wr_data;
    else                       rd_data1 = r_rf[rd_addr1];

    if (rd_addr2 == ZERO_ADDR) rd_data2 = '0;
    else if (w_hit2)           rd_data2 = wr_data;
    else                       rd_data2 = r_rf[rd_addr2];

    rd_busy1 = w_hit1 ? 1'b0 : w_busy_vec[rd_addr1];
    rd_busy2 = w_hit2 ? 1'b0 : w_busy_vec[rd_addr2];
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .busy_vec (w_busy_vec),
    .waw_err  (waw_err)
  );

  assign busy_vec = w_busy_vec;
  assign any_busy = |w_busy_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance
// share all inputs; expected values are hand-computed constants.
module tb_regfile_sb;

  localparam int W    = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   rd_addr1, rd_addr2, wr_addr, iss_addr;
  logic            wr_en, iss_en, flush;
  logic [W-1:0]    wr_data;

  logic [W-1:0]    b_rd_data1, b_rd_data2, n_rd_data1, n_rd_data2;
  logic            b_rd_busy1, b_rd_busy2, n_rd_busy1, n_rd_busy2;
  logic [NREG-1:0] b_busy_vec, n_busy_vec;
  logic            b_any_busy, n_any_busy, b_waw_err, n_waw_err;

  int n_cmp;
  int n_err;

  regfile_sb #(.W(W), .NREG(NREG), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_vec(b_busy_vec), .any_busy(b_any_busy), .waw_err(b_waw_err)
  );

  regfile_sb #(.W(W), .NREG(NREG), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd_data1), .rd_data2(n_rd_data2),
    .rd_busy1(n_rd_busy1), .rd_busy2(n_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_vec(n_busy_vec), .any_busy(n_any_busy), .waw_err(n_waw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks follow at +1 more.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; iss_addr = '0;
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0; wr_data = '0;

    // Reset state
    #2;
    chk("rst_data1", b_rd_data1, 0);
    chk("rst_busy_vec", b_busy_vec, 0);
    chk("rst_any_busy", b_any_busy, 0);
    chk("rst_waw", b_waw_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Write r5, read on both ports
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    #1;
    chk("byp_same_cycle_r5", b_rd_data1, 32'hDEADBEEF);
    chk("nob_same_cycle_r5_old", n_rd_data1, 32'h0);
    tick(); idle(); #1;
    chk("r5_port1", b_rd_data1, 32'hDEADBEEF);
    chk("r5_port2", b_rd_data2, 32'hDEADBEEF);
    chk("nob_r5_port1", n_rd_data1, 32'hDEADBEEF);
    chk("nob_r5_port2", n_rd_data2, 32'hDEADBEEF);
    chk("r5_write_no_waw", b_waw_err, 0);

    // r0 hardwired
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr1 = 5'd0;
    #1;
    chk("r0_bypass_blocked", b_rd_data1, 0);
    tick(); idle(); #1;
    chk("r0_read", b_rd_data1, 0);
    chk("nob_r0_read", n_rd_data1, 0);
    iss_en = 1'b1; iss_addr = 5'd0;
    tick(); iss_en = 1'b1; iss_addr = 5'd0;
    tick(); idle(); #1;
    chk("r0_issue_busy_vec", b_busy_vec, 0);
    chk("r0_issue_waw", b_waw_err, 0);

    // Bypass vs non-bypass on r7, with a busy r7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;
    tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd7;
    tick(); idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr1 = 5'd7;
    #1;
    chk("byp_r7_data", b_rd_data1, 32'hA5A5A5A5);
    chk("byp_r7_busy", b_rd_busy1, 0);
    chk("nob_r7_old_data", n_rd_data1, 32'h11111111);
    chk("nob_r7_busy", n_rd_busy1, 1);
    tick(); idle(); #1;
    chk("nob_r7_new_data", n_rd_data1, 32'hA5A5A5A5);
    chk("r7_busy_cleared", b_busy_vec, 0);

    // Issue / writeback on r3
    iss_en = 1'b1; iss_addr = 5'd3; rd_addr2 = 5'd3;
    tick(); idle(); #1;
    chk("r3_busy_vec", b_busy_vec, 32'h8);
    chk("r3_any_busy", b_any_busy, 1);
    chk("r3_rd_busy2", b_rd_busy2, 1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick(); idle(); #1;
    chk("r3_wb_clear", b_busy_vec, 0);
    chk("r3_wb_any_busy", b_any_busy, 0);
    iss_en = 1'b1; iss_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
    tick(); idle(); #1;
    chk("r3_iss_beats_wb", b_busy_vec, 32'h8);
    chk("r3_iss_wb_waw", b_waw_err, 0);
    iss_en = 1'b1; iss_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h35;
    tick(); idle(); #1;
    chk("r3_busy_iss_wb_no_waw", b_waw_err, 0);
    chk("r3_busy_iss_wb_busy", n_busy_vec, 32'h8);
    wr_en = 1'b1; wr_addr = 5'd3;
    tick(); idle(); #1;
    chk("r3_final_clear", b_busy_vec, 0);

    // WAW on r4, sticky
    iss_en = 1'b1; iss_addr = 5'd4;
    tick(); idle(); #1;
    chk("r4_busy", b_busy_vec, 32'h10);
    chk("r4_no_waw_yet", b_waw_err, 0);
    iss_en = 1'b1; iss_addr = 5'd4;
    tick(); idle(); #1;
    chk("r4_waw_set", b_waw_err, 1);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    tick(); idle(); #1;
    chk("r4_wb_clear", b_busy_vec, 0);
    chk("r4_waw_sticky", b_waw_err, 1);
    chk("nob_r4_waw_sticky", n_waw_err, 1);

    // Flush with simultaneous issue and writeback
    iss_en = 1'b1; iss_addr = 5'd2;
    tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd9;
    tick(); idle(); #1;
    chk("r2_r9_busy", b_busy_vec, 32'h204);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd11;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
    tick(); idle(); rd_addr1 = 5'd2; rd_addr2 = 5'd11; #1;
    chk("flush_busy_vec", b_busy_vec, 0);
    chk("flush_any_busy", b_any_busy, 0);
    chk("flush_r2_data", n_rd_data1, 32'h55);
    chk("flush_r11_busy", b_rd_busy2, 0);

    // Asynchronous reset mid-cycle, with a would-be bypass hit present
    rd_addr1 = 5'd5;
    #1;
    chk("pre_reset_r5", b_rd_data1, 32'hDEADBEEF);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77777777;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_byp_data1", b_rd_data1, 0);
    chk("async_rst_nob_data1", n_rd_data1, 0);
    chk("async_rst_waw", b_waw_err, 0);
    idle();
    #1;
    chk("async_rst_r5_cleared", n_rd_data1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
